// File: rtl/clock_set_ctl.sv
// Time-set mode controller: RUN / SET_HR / SET_MIN sequencing, inc edge and
// auto-repeat pulse generation, seconds freeze, and blink mask for the edited field.
module clock_set_ctl #(
    parameter int HOLD_CYC    = 50_000_000,
    parameter int REPEAT_CYC  = 10_000_000,
    parameter int BLINK_CYC   = 25_000_000,
    parameter int TIMEOUT_CYC = 1_000_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_pulse,
    input  logic       inc_level,
    output logic       adv_hr,
    output logic       adv_min,
    output logic       run_en,
    output logic [7:0] blink_mask,
    output logic [1:0] mode_state
);

    localparam logic [1:0] ST_RUN = 2'b00;
    localparam logic [1:0] ST_HR  = 2'b01;
    localparam logic [1:0] ST_MIN = 2'b10;

    localparam int HW = $clog2(((HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC) + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int BW = $clog2(BLINK_CYC + 1);

    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYC - 1);
    localparam logic [HW-1:0] REP_LAST   = HW'(REPEAT_CYC - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

    logic [1:0]    state;
    logic          inc_q;
    logic [HW-1:0] hold_cnt;
    logic          repeating;
    logic          inhibit;
    logic [TW-1:0] to_cnt;
    logic [BW-1:0] blink_cnt;
    logic          phase;

    logic          set_st, inc_rise, rep_tick, rep_fire, step_evt;
    logic          activity, fire, timeout, changed;
    logic [1:0]    state_next;
    logic [BW-1:0] blink_cnt_next;
    logic          phase_next;
    logic [7:0]    mask_next;

    always_comb begin
        set_st   = (state == ST_HR) || (state == ST_MIN);
        inc_rise = inc_level & ~inc_q;
        // First tick after HOLD_CYC held cycles, then every REPEAT_CYC.
        rep_tick = inc_level & inc_q &
                   (repeating ? (hold_cnt == REP_LAST) : (hold_cnt == HOLD_LAST));
        rep_fire = rep_tick & ~inhibit & set_st;
        step_evt = set_st & (inc_rise | rep_fire);
        activity = mode_pulse | step_evt;
        fire     = step_evt & ~mode_pulse;
        timeout  = set_st & ~activity & (to_cnt == TO_LAST);

        state_next = ST_RUN;
        case (state)
            ST_RUN:  state_next = mode_pulse ? ST_HR : ST_RUN;
            ST_HR:   state_next = mode_pulse ? ST_MIN : (timeout ? ST_RUN : ST_HR);
            ST_MIN:  state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
        if (state == ST_MIN && !mode_pulse && !timeout) state_next = ST_MIN;
        changed = (state_next != state);

        // Entering a state or stepping a value restarts blink with digits visible.
        blink_cnt_next = blink_cnt;
        phase_next     = phase;
        if (changed || fire) begin
            blink_cnt_next = '0;
            phase_next     = 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt_next = '0;
            phase_next     = ~phase;
        end else if (blink_cnt != {BW{1'b1}}) begin
            blink_cnt_next = blink_cnt + BW'(1);
        end

        mask_next = 8'h00;
        if (phase_next) begin
            if (state_next == ST_HR)       mask_next = 8'b1100_0000;
            else if (state_next == ST_MIN) mask_next = 8'b0011_0000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            inc_q      <= 1'b0;
            hold_cnt   <= '0;
            repeating  <= 1'b0;
            inhibit    <= 1'b0;
            to_cnt     <= '0;
            blink_cnt  <= '0;
            phase      <= 1'b0;
            adv_hr     <= 1'b0;
            adv_min    <= 1'b0;
            run_en     <= 1'b1;
            blink_mask <= 8'h00;
        end else begin
            state     <= state_next;
            inc_q     <= inc_level;
            blink_cnt <= blink_cnt_next;
            phase     <= phase_next;

            if (inc_rise || !inc_level || rep_tick) begin
                hold_cnt  <= '0;
                repeating <= inc_level & ~inc_rise;
            end else if (hold_cnt != {HW{1'b1}}) begin
                hold_cnt <= hold_cnt + HW'(1);
            end

            // A mode change blocks repeats from a button already held down.
            if (changed)         inhibit <= 1'b1;
            else if (!inc_level) inhibit <= 1'b0;

            if (changed || activity || !set_st) to_cnt <= '0;
            else if (to_cnt != {TW{1'b1}})      to_cnt <= to_cnt + TW'(1);

            adv_hr     <= fire & (state == ST_HR);
            adv_min    <= fire & (state == ST_MIN);
            run_en     <= (state_next == ST_RUN);
            blink_mask <= mask_next;
        end
    end

    assign mode_state = state;

endmodule

// File: tb/tb_clock_set_ctl.sv
// Bench for clock_set_ctl: directed scenarios plus random traffic, every cycle
// compared against a time-based behavioural model of the set-mode rules.
module tb_clock_set_ctl;

    localparam int HOLD    = 8;
    localparam int REPEAT  = 4;
    localparam int BLINK   = 3;
    localparam int TIMEOUT = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mode_pulse = 1'b0;
    logic       inc_level = 1'b0;
    logic       adv_hr, adv_min, run_en;
    logic [7:0] blink_mask;
    logic [1:0] mode_state;

    int errors = 0;
    int checks = 0;

    // Model state: everything is a cycle timestamp or a plain mode number.
    int t = 0;
    int m_state = 0;
    int m_press = -1000;
    int m_act = 0;
    int m_bref = 0;
    bit m_inh = 0;
    bit m_prev = 0;
    logic       e_hr, e_min, e_run;
    logic [7:0] e_mask;
    logic [1:0] e_state;

    logic [7:0] exp_q[$];
    logic [7:0] obs_hr[$];
    logic [7:0] obs_min[$];

    clock_set_ctl #(
        .HOLD_CYC(HOLD), .REPEAT_CYC(REPEAT), .BLINK_CYC(BLINK), .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .mode_pulse(mode_pulse), .inc_level(inc_level),
        .adv_hr(adv_hr), .adv_min(adv_min), .run_en(run_en),
        .blink_mask(blink_mask), .mode_state(mode_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, want, t);
        end
    endtask

    // Expected outputs one cycle after inputs (r, mp, inc) are applied in cycle t.
    task automatic model(input bit r, input bit mp, input bit inc);
        bit rise, rep, set_st, act, fire;
        int k, nxt, ph;
        e_hr  = 1'b0;
        e_min = 1'b0;
        if (r) begin
            m_state = 0; m_inh = 0; m_prev = 0; m_act = t; m_bref = t;
        end else begin
            rise = inc && !m_prev;
            if (rise) m_press = t;
            k      = t - m_press;
            set_st = (m_state != 0);
            rep    = inc && !rise && k >= HOLD && ((k - HOLD) % REPEAT == 0) && !m_inh && set_st;
            act    = mp || (set_st && (rise || rep));
            fire   = set_st && (rise || rep) && !mp;
            nxt    = m_state;
            if (mp) nxt = (m_state + 1) % 3;
            else if (set_st && !act && (t - m_act) >= TIMEOUT) nxt = 0;
            e_hr  = fire && (m_state == 1);
            e_min = fire && (m_state == 2);
            if (nxt != m_state) begin
                m_inh = 1; m_act = t; m_bref = t;
            end else begin
                if (!inc) m_inh = 0;
                if (act)  m_act = t;
                if (fire) m_bref = t;
            end
            m_state = nxt;
            m_prev  = inc;
        end
        ph      = ((t - m_bref) / BLINK) % 2;
        e_mask  = (ph == 1) ? ((m_state == 1) ? 8'hC0 : (m_state == 2) ? 8'h30 : 8'h00) : 8'h00;
        e_run   = (m_state == 0);
        e_state = 2'(m_state);
    endtask

    task automatic step(input bit r, input bit mp, input bit inc);
        rst = r; mode_pulse = mp; inc_level = inc;
        model(r, mp, inc);
        @(posedge clk);
        #1;
        check("adv_hr", {7'd0, adv_hr}, {7'd0, e_hr});
        check("adv_min", {7'd0, adv_min}, {7'd0, e_min});
        check("run_en", {7'd0, run_en}, {7'd0, e_run});
        check("blink_mask", blink_mask, e_mask);
        check("mode_state", {6'd0, mode_state}, {6'd0, e_state});
        t++;
    endtask

    // Rising edge then hold; pulse offsets are relative to the first high cycle.
    task automatic press(input int hold_n, input int tail_n);
        int n0, ti;
        n0 = t;
        obs_hr.delete();
        obs_min.delete();
        for (int i = 0; i < hold_n + tail_n; i++) begin
            ti = t;
            step(0, 0, i < hold_n);
            if (adv_hr)  obs_hr.push_back(8'(ti + 1 - n0));
            if (adv_min) obs_min.push_back(8'(ti + 1 - n0));
        end
    endtask

    task automatic compare_q(input string tag, input logic [7:0] got[$]);
        check({tag, "_count"}, 8'(got.size()), 8'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check(tag, got[i], exp_q[i]);
    endtask

    initial begin
        logic [1:0] st_want [3];
        logic [7:0] masks [64];
        int n0, ti, found, pulses, run_left;
        bit inc_r;
        st_want = '{2'b01, 2'b10, 2'b00};

        // Mode cycling from reset
        step(1, 0, 0);
        check("reset_state", {6'd0, mode_state}, 8'h00);
        check("reset_run_en", {7'd0, run_en}, 8'h01);
        check("reset_mask", blink_mask, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0);
            check("cycle_state", {6'd0, mode_state}, {6'd0, st_want[i]});
            check("cycle_run_en", {7'd0, run_en}, {7'd0, (i == 2)});
            step(0, 0, 0);
        end

        // Single increment in SET_HR, then in RUN
        step(1, 0, 0); step(0, 1, 0); step(0, 0, 0);
        press(3, 3);
        exp_q = '{8'd1};
        compare_q("single_hr", obs_hr);
        exp_q.delete();
        compare_q("single_min", obs_min);
        step(1, 0, 0);
        press(3, 3);
        compare_q("run_hr", obs_hr);
        compare_q("run_min", obs_min);

        // Auto-repeat in SET_MIN
        step(1, 0, 0); step(0, 1, 0); step(0, 0, 0); step(0, 1, 0); step(0, 0, 0);
        press(30, 8);
        exp_q = '{8'd1, 8'd9, 8'd13, 8'd17, 8'd21, 8'd25, 8'd29};
        compare_q("repeat_min", obs_min);
        exp_q.delete();
        compare_q("repeat_hr", obs_hr);

        // Blink phases and inactivity timeout in SET_HR
        step(1, 0, 0); step(0, 0, 0);
        n0 = t;
        found = -1;
        step(0, 1, 0);
        masks[1] = blink_mask;
        for (int i = 0; i < 60 && found < 0; i++) begin
            ti = t;
            step(0, 0, 0);
            if (ti + 1 - n0 < 64) masks[ti + 1 - n0] = blink_mask;
            if (mode_state == 2'b00) found = ti + 1 - n0;
        end
        check("blink_off1", masks[3], 8'h00);
        check("blink_on4", masks[4], 8'hC0);
        check("blink_on6", masks[6], 8'hC0);
        check("blink_off7", masks[7], 8'h00);
        check("blink_on10", masks[10], 8'hC0);
        check("timeout_cycle", 8'(found), 8'd41);

        n0 = t;
        step(0, 1, 0); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
        check("pre_adv_mask", blink_mask, 8'hC0);
        step(0, 0, 1);
        check("adv_hr_pulse", {7'd0, adv_hr}, 8'h01);
        check("adv_mask_visible", blink_mask, 8'h00);
        step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
        check("blink_restart", blink_mask, 8'hC0);

        // Collision of mode_pulse and inc edge, then a long hold
        step(1, 0, 0); step(0, 1, 0); step(0, 0, 0);
        step(0, 1, 1);
        check("collide_state", {6'd0, mode_state}, 8'h02);
        check("collide_hr", {7'd0, adv_hr}, 8'h00);
        check("collide_min", {7'd0, adv_min}, 8'h00);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1);
            pulses += int'(adv_hr) + int'(adv_min);
        end
        check("collide_no_repeat", 8'(pulses), 8'd0);
        step(0, 0, 0);

        // Reset in the middle of a held repeat
        step(1, 0, 0); step(0, 1, 0); step(0, 0, 0); step(0, 1, 0); step(0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 1);
        step(1, 0, 1);
        check("rst_state", {6'd0, mode_state}, 8'h00);
        check("rst_run_en", {7'd0, run_en}, 8'h01);
        check("rst_mask", blink_mask, 8'h00);
        pulses = int'(adv_hr) + int'(adv_min);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1);
            pulses += int'(adv_hr) + int'(adv_min);
        end
        check("rst_no_pulses", 8'(pulses), 8'd0);

        // Random traffic against the model
        step(1, 0, 0);
        inc_r = 0;
        run_left = 0;
        for (int i = 0; i < 2000; i++) begin
            if (run_left == 0) begin
                inc_r = ~inc_r;
                run_left = $urandom_range(1, 30);
            end
            run_left--;
            step($urandom_range(0, 300) == 0, $urandom_range(0, 40) == 0, inc_r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
